// File: rtl/alu_cont_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_cont_pkg
// Brief    : Shared constants for the ALU control decoder: ALU select codes,
//            ALUOp encodings from main control and R-type funct[3:0] codes.
// Revision : 1.0 - initial release
// ============================================================================
package alu_cont_pkg;

  // ALU operation select codes
  localparam logic [3:0] ALU_AND     = 4'b0000;
  localparam logic [3:0] ALU_OR      = 4'b0001;
  localparam logic [3:0] ALU_ADD     = 4'b0010;
  localparam logic [3:0] ALU_XOR     = 4'b0011;
  localparam logic [3:0] ALU_SRA     = 4'b1000;
  localparam logic [3:0] ALU_SUB     = 4'b0110;
  localparam logic [3:0] ALU_SLT     = 4'b0111;
  localparam logic [3:0] ALU_NOR     = 4'b1100;
  localparam logic [3:0] ALU_INVALID = 4'b1111;

  // ALUOp encodings issued by main control
  localparam logic [2:0] ALUOP_ADD   = 3'b000;
  localparam logic [2:0] ALUOP_SUB   = 3'b001;
  localparam logic [2:0] ALUOP_ANDI  = 3'b010;
  localparam logic [2:0] ALUOP_ORI   = 3'b011;
  localparam logic [2:0] ALUOP_RTYPE = 3'b100;
  localparam logic [2:0] ALUOP_SLTI  = 3'b101;
  localparam logic [2:0] ALUOP_XORI  = 3'b110;

  // R-type funct[3:0] codes
  localparam logic [3:0] FUNCT_ADD = 4'b0000;
  localparam logic [3:0] FUNCT_SUB = 4'b0010;
  localparam logic [3:0] FUNCT_AND = 4'b0100;
  localparam logic [3:0] FUNCT_OR  = 4'b0101;
  localparam logic [3:0] FUNCT_XOR = 4'b0110;
  localparam logic [3:0] FUNCT_NOR = 4'b0111;
  localparam logic [3:0] FUNCT_SLT = 4'b1010;
  localparam logic [3:0] FUNCT_SRA = 4'b0011;

endpackage : alu_cont_pkg
`default_nettype wire

// File: rtl/alu_cont_dec.sv
`default_nettype none
// ============================================================================
// Module   : alu_cont_dec
// Brief    : Combinational ALU control decode: ALUOp + funct[3:0] to the next
//            ALU select and the next illegal flag.
//            Option macro: ALU_CONT_ILLEGAL_DET_EN (illegal output present,
//            undefined combinations select 1111 instead of ADD).
// Revision : 1.0 - initial release
// ============================================================================
module alu_cont_dec
  import alu_cont_pkg::*;
(
  input  logic [2:0] aluop,
  input  logic [3:0] funct,
`ifdef ALU_CONT_ILLEGAL_DET_EN
  output logic       illegal_nxt,
`endif
  output logic [3:0] gout_nxt
);

  // Select driven for undefined combinations
`ifdef ALU_CONT_ILLEGAL_DET_EN
  localparam logic [3:0] c_UNDEF_SEL = ALU_INVALID;
`else
  localparam logic [3:0] c_UNDEF_SEL = ALU_ADD;
`endif

  logic [3:0] w_sel;
  logic       w_undef;

  // Decode; funct is only examined on the R-type branch so that X/Z on it
  // cannot leak into the select for immediate/memory/branch ops
  always_comb begin
    w_sel   = ALU_ADD;
    w_undef = 1'b0;
    case (aluop)
      ALUOP_ADD:  w_sel = ALU_ADD;
      ALUOP_SUB:  w_sel = ALU_SUB;
      ALUOP_ANDI: w_sel = ALU_AND;
      ALUOP_ORI:  w_sel = ALU_OR;
      ALUOP_SLTI: w_sel = ALU_SLT;
      ALUOP_XORI: w_sel = ALU_XOR;
      ALUOP_RTYPE: begin
        case (funct)
          FUNCT_ADD: w_sel = ALU_ADD;
          FUNCT_SUB: w_sel = ALU_SUB;
          FUNCT_AND: w_sel = ALU_AND;
          FUNCT_OR:  w_sel = ALU_OR;
          FUNCT_XOR: w_sel = ALU_XOR;
          FUNCT_NOR: w_sel = ALU_NOR;
          FUNCT_SLT: w_sel = ALU_SLT;
          FUNCT_SRA: w_sel = ALU_SRA;
          default:   w_undef = 1'b1;
        endcase
      end
      default: w_undef = 1'b1;
    endcase
  end

  assign gout_nxt = w_undef ? c_UNDEF_SEL : w_sel;

`ifdef ALU_CONT_ILLEGAL_DET_EN
  assign illegal_nxt = w_undef;
`endif

endmodule : alu_cont_dec
`default_nettype wire

// File: rtl/alu_cont.sv
`default_nettype none
// ============================================================================
// Module   : alu_cont
// Brief    : Registered ALU control decoder. Captures the decoded ALU select
//            on enabled clock edges; async active-high reset to ADD.
//            Option macro: ALU_CONT_ILLEGAL_DET_EN (adds illegal and
//            illegal_sticky outputs).
// Revision : 1.0 - initial release
// ============================================================================
module alu_cont
  import alu_cont_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       aluop2,
  input  logic       aluop1,
  input  logic       aluop0,
  input  logic       f3,
  input  logic       f2,
  input  logic       f1,
  input  logic       f0,
`ifdef ALU_CONT_ILLEGAL_DET_EN
  output logic       illegal,
  output logic       illegal_sticky,
`endif
  output logic [3:0] gout
);

  logic [2:0] w_aluop;
  logic [3:0] w_funct;
  logic [3:0] w_gout_nxt;

  assign w_aluop = {aluop2, aluop1, aluop0};
  assign w_funct = {f3, f2, f1, f0};

`ifdef ALU_CONT_ILLEGAL_DET_EN
  logic w_illegal_nxt;

  alu_cont_dec u_dec (
    .aluop       (w_aluop),
    .funct       (w_funct),
    .illegal_nxt (w_illegal_nxt),
    .gout_nxt    (w_gout_nxt)
  );

  // Illegal flag follows the captured decode; sticky copy latches until reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      illegal        <= 1'b0;
      illegal_sticky <= 1'b0;
    end else if (en) begin
      illegal <= w_illegal_nxt;
      if (w_illegal_nxt) begin
        illegal_sticky <= 1'b1;
      end
    end
  end
`else
  alu_cont_dec u_dec (
    .aluop    (w_aluop),
    .funct    (w_funct),
    .gout_nxt (w_gout_nxt)
  );
`endif

  // Pipeline register for the ALU select; resets to ADD
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gout <= ALU_ADD;
    end else if (en) begin
      gout <= w_gout_nxt;
    end
  end

endmodule : alu_cont
`default_nettype wire

// File: tb/tb_alu_cont.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_cont
// Brief    : Directed self-checking bench for alu_cont.
//            Option macro: ALU_CONT_ILLEGAL_DET_EN (checks illegal flags).
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_cont;

`ifdef ALU_CONT_ILLEGAL_DET_EN
  localparam logic [3:0] c_UNDEF = 4'b1111;
`else
  localparam logic [3:0] c_UNDEF = 4'b0010;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en  = 1'b0;
  logic [2:0] aluop = 3'b000;
  logic [3:0] funct = 4'b0000;
  logic [3:0] gout;
`ifdef ALU_CONT_ILLEGAL_DET_EN
  logic       illegal;
  logic       illegal_sticky;
`endif

  int checks = 0;
  int errors = 0;

  alu_cont dut (
    .clk            (clk),
    .rst            (rst),
    .en             (en),
    .aluop2         (aluop[2]),
    .aluop1         (aluop[1]),
    .aluop0         (aluop[0]),
    .f3             (funct[3]),
    .f2             (funct[2]),
    .f1             (funct[1]),
    .f0             (funct[0]),
`ifdef ALU_CONT_ILLEGAL_DET_EN
    .illegal        (illegal),
    .illegal_sticky (illegal_sticky),
`endif
    .gout           (gout)
  );

  // 10-unit clock, rising edges at 5, 15, 25, ...
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Drive inputs between edges, then move to 1 unit past the next rising edge
  task automatic apply(input logic [2:0] op, input logic [3:0] f, input logic e);
    aluop = op;
    funct = f;
    en    = e;
    @(posedge clk);
    #1;
  endtask

  logic [3:0] ops_exp [5];
  logic [2:0] ops     [5];
  logic [3:0] rf      [8];
  logic [3:0] rf_exp  [8];

  initial begin
    ops     = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b101};
    ops_exp = '{4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b0111};
    rf      = '{4'b0100, 4'b0101, 4'b0000, 4'b0010, 4'b1010, 4'b0111, 4'b0110, 4'b0011};
    rf_exp  = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100, 4'b0011, 4'b1000};

    // Reset pulse before any rising edge: outputs settle at once
    #2 rst = 1'b1;
    #1;
    chk("reset_gout", gout, 4'b0010);
`ifdef ALU_CONT_ILLEGAL_DET_EN
    chk("reset_illegal", {3'b000, illegal}, 4'b0000);
    chk("reset_sticky", {3'b000, illegal_sticky}, 4'b0000);
`endif
    #7 rst = 1'b0;  // t=10, between edges

    // Non-R-type ALUOps with defined funct, then with funct = X
    for (int i = 0; i < 5; i++) begin
      apply(ops[i], 4'b0101, 1'b1);
      chk($sformatf("aluop_%b", ops[i]), gout, ops_exp[i]);
    end
    for (int i = 0; i < 5; i++) begin
      apply(ops[i], 4'bxxxx, 1'b1);
      chk($sformatf("aluop_%b_fx", ops[i]), gout, ops_exp[i]);
    end

    // R-type funct decode
    for (int i = 0; i < 8; i++) begin
      apply(3'b100, rf[i], 1'b1);
      chk($sformatf("rtype_%b", rf[i]), gout, rf_exp[i]);
`ifdef ALU_CONT_ILLEGAL_DET_EN
      chk($sformatf("rtype_%b_illegal", rf[i]), {3'b000, illegal}, 4'b0000);
`endif
    end

    // Undefined combinations
    apply(3'b100, 4'b1111, 1'b1);
    chk("rtype_1111", gout, c_UNDEF);
`ifdef ALU_CONT_ILLEGAL_DET_EN
    chk("rtype_1111_illegal", {3'b000, illegal}, 4'b0001);
    chk("rtype_1111_sticky", {3'b000, illegal_sticky}, 4'b0001);
`endif
    apply(3'b111, 4'b0000, 1'b1);
    chk("aluop_111", gout, c_UNDEF);
`ifdef ALU_CONT_ILLEGAL_DET_EN
    chk("aluop_111_illegal", {3'b000, illegal}, 4'b0001);
`endif
    apply(3'b000, 4'b0000, 1'b1);
    chk("legal_after_illegal", gout, 4'b0010);
`ifdef ALU_CONT_ILLEGAL_DET_EN
    chk("legal_after_illegal_flag", {3'b000, illegal}, 4'b0000);
    chk("sticky_holds", {3'b000, illegal_sticky}, 4'b0001);
`endif

    // Enable low holds; raising it captures one cycle later
    for (int i = 0; i < 3; i++) begin
      apply(3'b001, 4'b0000, 1'b0);
      chk($sformatf("hold_%0d", i), gout, 4'b0010);
    end
    apply(3'b001, 4'b0000, 1'b1);
    chk("en_resume", gout, 4'b0110);

    // Hold with en low across an illegal input: flags must not move
    apply(3'b111, 4'b0000, 1'b0);
    chk("hold_illegal_gout", gout, 4'b0110);

    // Asynchronous reset between edges
    apply(3'b100, 4'b0111, 1'b1);
    chk("nor_before_rst", gout, 4'b1100);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_gout", gout, 4'b0010);
`ifdef ALU_CONT_ILLEGAL_DET_EN
    chk("async_rst_sticky", {3'b000, illegal_sticky}, 4'b0000);
`endif

    // Reset held across an edge with an illegal input: reset wins
    apply(3'b111, 4'b1111, 1'b1);
    chk("rst_wins_gout", gout, 4'b0010);
`ifdef ALU_CONT_ILLEGAL_DET_EN
    chk("rst_wins_illegal", {3'b000, illegal}, 4'b0000);
    chk("rst_wins_sticky", {3'b000, illegal_sticky}, 4'b0000);
`endif

    // First capture after deassertion
    #4 rst = 1'b0;
    apply(3'b110, 4'b0000, 1'b1);
    chk("first_after_rst", gout, 4'b0011);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_alu_cont
`default_nettype wire
